// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - UART (8N1) to register-bus bridge for the GPIO register block
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (assert async, release synchronised internally)
//   rx         in   UART receive line, idle high, asynchronous to clk
//   tx         out  UART transmit line, idle high
//   reg_addr   out  [ADDR_W] register address, latched from the command byte
//   reg_wdata  out  [DATA_W] register write data, latched from the data byte
//   reg_we     out  one-cycle write strobe
//   reg_rdata  in   [DATA_W] register read data, combinational from reg_addr
//   busy       out  high from command acceptance until the write strobe or TX stop bit end
//   frame_err  out  one-cycle pulse when a received stop bit samples low
//
// Command byte: bit7 = 1 write / 0 read, bits6:4 must be 000, bits3:0 = address.
// A write is followed by one data byte; a read answers with one byte on tx.

module uart_reg_bridge #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              tx,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  // --------------------------------------------------------------------------
  // Reset: asserts immediately, releases on a clock edge
  // --------------------------------------------------------------------------
  logic [1:0] rst_pipe;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_sync_n = rst_pipe[1];

  // --------------------------------------------------------------------------
  // RX line synchroniser (reset to idle-high so no false start after reset)
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // RX FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT
  } rx_state_t;

  rx_state_t          rx_state, rx_state_next;
  logic [CNT_W-1:0]   rx_cnt;
  logic [BIT_W-1:0]   rx_bit_idx;
  logic [DATA_W-1:0]  rx_shreg;
  logic               rx_bit_end;
  logic               rx_half;
  logic               rx_valid;
  logic               rx_valid_d;
  logic               frame_err_d;

  assign rx_bit_end = (rx_cnt == CNT_LAST);
  assign rx_half    = (rx_cnt == CNT_HALF);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) rx_state <= R_IDLE;
    else             rx_state <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      R_IDLE:  if (!rx_sync) rx_state_next = R_START;
      // Mid-start re-check: a line already back high was a glitch.
      R_START: if (rx_half) rx_state_next = rx_sync ? R_IDLE : R_DATA;
      R_DATA:  if (rx_bit_end && rx_bit_idx == BIT_LAST) rx_state_next = R_STOP;
      // After a bad stop bit the line may still be low; R_WAIT holds off
      // rearming until it returns high so the same low is not seen as a start.
      R_STOP:  if (rx_bit_end) rx_state_next = rx_sync ? R_IDLE : R_WAIT;
      R_WAIT:  if (rx_sync) rx_state_next = R_IDLE;
      default: rx_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (rx_state == R_STOP && rx_bit_end) begin
      rx_valid_d  = rx_sync;
      frame_err_d = !rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_shreg   <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid  <= rx_valid_d;
      frame_err <= frame_err_d;

      // Counter restarts on every state change and every bit boundary, so
      // the first data sample lands one full bit after the mid-start sample.
      if (rx_state == R_IDLE || rx_state == R_WAIT ||
          rx_state_next != rx_state || rx_bit_end)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + CNT_W'(1);

      if (rx_state == R_START)
        rx_bit_idx <= '0;
      else if (rx_state == R_DATA && rx_bit_end)
        rx_bit_idx <= rx_bit_idx + BIT_W'(1);

      // LSB arrives first, so shift in from the top.
      if (rx_state == R_DATA && rx_bit_end)
        rx_shreg <= {rx_sync, rx_shreg[DATA_W-1:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Command parser FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    P_CMD,
    P_DATA,
    P_WRITE,
    P_RSETUP,
    P_RSAMPLE,
    P_TX
  } p_state_t;

  p_state_t p_state, p_state_next;
  logic     cmd_ok;
  logic     cmd_accept;
  logic     reg_we_d;
  logic     busy_d;
  logic     tx_start;
  logic     tx_done;

  assign cmd_ok     = (rx_shreg[6:4] == 3'b000);
  assign cmd_accept = (p_state == P_CMD) && rx_valid && cmd_ok;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) p_state <= P_CMD;
    else             p_state <= p_state_next;
  end

  always_comb begin
    p_state_next = p_state;
    case (p_state)
      P_CMD:     if (cmd_accept) p_state_next = rx_shreg[7] ? P_DATA : P_RSETUP;
      // A corrupted frame abandons a half-received write. Other states are
      // either one-cycle transients or P_TX, which must run to completion.
      P_DATA: begin
        if (frame_err)     p_state_next = P_CMD;
        else if (rx_valid) p_state_next = P_WRITE;
      end
      P_WRITE:   p_state_next = P_CMD;
      P_RSETUP:  p_state_next = P_RSAMPLE;
      P_RSAMPLE: p_state_next = P_TX;
      // Bytes completing while here are simply not looked at.
      P_TX:      if (tx_done) p_state_next = P_CMD;
      default:   p_state_next = P_CMD;
    endcase
  end

  always_comb begin
    reg_we_d = (p_state == P_WRITE);
    busy_d   = (p_state_next != P_CMD);
    tx_start = (p_state == P_RSAMPLE);
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= reg_we_d;
      busy   <= busy_d;
      if (cmd_accept)
        reg_addr <= ADDR_W'(rx_shreg[3:0]);
      if (p_state == P_DATA && rx_valid)
        reg_wdata <= rx_shreg;
    end
  end

  // --------------------------------------------------------------------------
  // TX FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } tx_state_t;

  tx_state_t          tx_state, tx_state_next;
  logic [CNT_W-1:0]   tx_cnt;
  logic [BIT_W-1:0]   tx_bit_idx;
  logic [DATA_W-1:0]  tx_shreg;
  logic               tx_bit_end;
  logic               tx_d;

  assign tx_bit_end = (tx_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) tx_state <= T_IDLE;
    else             tx_state <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      T_IDLE:  if (tx_start) tx_state_next = T_START;
      T_START: if (tx_bit_end) tx_state_next = T_DATA;
      T_DATA:  if (tx_bit_end && tx_bit_idx == BIT_LAST) tx_state_next = T_STOP;
      T_STOP:  if (tx_bit_end) tx_state_next = T_IDLE;
      default: tx_state_next = T_IDLE;
    endcase
  end

  // tx is registered from the level the next state drives, so the line
  // changes on the same edge as tx_state and carries no combinational glitch.
  // tx_shreg[0] is the bit currently on the line; at a data bit boundary the
  // shift is happening this edge, so the following bit is [1].
  always_comb begin
    tx_done = (tx_state == T_STOP) && tx_bit_end;
    tx_d    = 1'b1;
    case (tx_state_next)
      T_START: tx_d = 1'b0;
      T_DATA:  tx_d = (tx_state == T_DATA && tx_bit_end) ? tx_shreg[1] : tx_shreg[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tx         <= 1'b1;
      tx_cnt     <= '0;
      tx_bit_idx <= '0;
      tx_shreg   <= '0;
    end else begin
      tx <= tx_d;

      if (tx_state == T_IDLE || tx_state_next != tx_state || tx_bit_end)
        tx_cnt <= '0;
      else
        tx_cnt <= tx_cnt + CNT_W'(1);

      if (tx_state == T_IDLE && tx_start) begin
        tx_shreg   <= reg_rdata;
        tx_bit_idx <= '0;
      end else if (tx_state == T_DATA && tx_bit_end) begin
        tx_shreg   <= {1'b0, tx_shreg[DATA_W-1:1]};
        tx_bit_idx <= tx_bit_idx + BIT_W'(1);
      end
    end
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Upstream host-access stage for the GPIO register block: receives 8N1 UART bytes on a pin, decodes them as register write/read commands, and drives the register-file address/wdata/we bus.
- Read responses are returned as UART bytes on tx.
- Sits between a ui_in/uio_in pin and the GPIO register instance in the TinyTapeout top.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); must be >= 4.
- ADDR_W, 4, register address width.
- DATA_W, 8, register data width; equals the UART byte width, fixed 8.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  UART receive line, idle high, asynchronous to clk
- tx  output  1  UART transmit line, idle high
- reg_addr  output  ADDR_W  register address to GPIO block
- reg_wdata  output  DATA_W  register write data
- reg_we  output  1  one-cycle write strobe
- reg_rdata  input  DATA_W  register read data; combinational from reg_addr, valid the cycle after reg_addr changes
- busy  output  1  high while a command is in progress (after command byte accepted, until write strobe or TX stop bit completes)
- frame_err  output  1  one-cycle pulse when a received stop bit samples 0

Behaviour:
- Reset (async assert, sync release): tx=1, reg_addr=0, reg_wdata=0, reg_we=0, busy=0, frame_err=0; RX, TX and parser return to idle; any partial byte or command is discarded.
- RX path:
  - rx passes through a 2-FF synchronizer.
  - A falling edge in idle starts a bit counter.
  - Start bit is re-sampled at CLKS_PER_BIT/2 (integer divide); if high, treat as a glitch and return to idle, no error.
  - Data bits are sampled every CLKS_PER_BIT thereafter, LSB first, then the stop bit.
  - Stop=1: rx_valid pulses one cycle with the byte.
  - Stop=0: frame_err pulses, byte discarded, parser forced to P_CMD.
  - RX waits for line high before rearming.
- Command byte format:
  - bit7=1 write, bit7=0 read; bits3:0 = address; bits6:4 must be 000.
  - A nonzero bits6:4 byte is ignored and the parser stays in P_CMD.
- Parser FSM:
  - P_CMD: on valid command byte, latch reg_addr=byte[3:0]; busy=1; write -> P_DATA, read -> P_RSETUP.
  - P_DATA: next rx_valid byte -> reg_wdata; -> P_WRITE.
  - P_WRITE: reg_we=1 for exactly one cycle; -> P_CMD, busy=0.
  - P_RSETUP: one cycle for address settle; -> P_RSAMPLE.
  - P_RSAMPLE: capture reg_rdata into tx shift register; start TX; -> P_TX.
  - P_TX: wait until TX stop bit completes; -> P_CMD, busy=0.
- TX path: start bit 0, 8 data bits LSB first, stop bit 1, each held CLKS_PER_BIT cycles; a read takes exactly 10*CLKS_PER_BIT cycles from P_RSAMPLE to return to P_CMD.
- Overlap and holding rules:
  - Bytes received while in P_TX are dropped with no error.
  - RX itself stays operational during TX (full duplex line).
  - reg_addr and reg_wdata hold their last values in all other states.
  - reg_we is never asserted outside P_WRITE.
- Latency: reg_we asserts 2 cycles after the data byte's rx_valid (1 cycle into P_WRITE registered).
- Boundaries:
  - Back-to-back frames with zero idle time between stop and next start are received correctly.
  - Reset mid-frame on either RX or TX returns tx to 1 immediately.

Test Plan:
- Write: CLKS_PER_BIT=8, send 0x83 then 0x5A -> exactly one reg_we pulse with reg_addr=3, reg_wdata=0x5A; busy falls the same cycle; no frame_err.
- Read: model reg_rdata=0xC4 when reg_addr=2, send 0x02 -> tx emits 0xC4 (start, 0,0,1,0,0,0,1,1, stop), 80 cycles of frame; reg_we never asserts.
- Framing error: send 0x81 with stop bit forced 0, then 0x81, 0x11 -> one frame_err pulse; single write of 0x11 to address 1; the corrupted byte has no effect.
- Glitch and invalid command: 2-cycle low pulse on rx -> no rx_valid; then send 0x70 -> ignored, busy stays 0; then 0x85, 0xFF -> write addr 5 data 0xFF.
- Overlap: send read 0x01, then a write command during TX -> the write is dropped (no reg_we); tx frame intact; next 0x81, 0x22 after busy falls writes correctly.
- Reset mid-operation: assert rst_n low during the TX data bits -> tx=1, busy=0, reg_* cleared while low; after release, a write 0x84, 0x0F completes normally.
